// File: rtl/toaplan_clk_rst_gen.sv
// Toaplan core clock-enable and reset sequencer.
// Takes the 70 MHz PLL clock and its lock flag. Produces the sequenced core reset
// and all clock enables: 68000 (two phases), sound CPU, pixel and fractional YM3812.
module toaplan_clk_rst_gen #(
  parameter int unsigned CPU_DIV  = 7,
  parameter int unsigned SND_DIV  = 20,
  parameter int unsigned PIX_DIV  = 10,
  parameter int unsigned FM_NUM   = 63,
  parameter int unsigned FM_DEN   = 1232,
  parameter int unsigned RST_HOLD = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  input  logic       i_pause,
  output logic       o_rst_sys,
  output logic       o_cen_cpu,
  output logic       o_cen_cpu_n,
  output logic       o_cen_snd,
  output logic       o_cen_pix,
  output logic       o_cen_fm,
  output logic [7:0] o_lock_drops
);

  localparam int unsigned CPU_W  = (CPU_DIV  > 1) ? $clog2(CPU_DIV)  : 1;
  localparam int unsigned SND_W  = (SND_DIV  > 1) ? $clog2(SND_DIV)  : 1;
  localparam int unsigned PIX_W  = (PIX_DIV  > 1) ? $clog2(PIX_DIV)  : 1;
  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int unsigned ACC_W  = 16;

  localparam logic [CPU_W-1:0]  CPU_LAST  = CPU_W'(CPU_DIV - 1);
  localparam logic [CPU_W-1:0]  CPU_HALF  = CPU_W'(CPU_DIV / 2 - 1);
  localparam logic [SND_W-1:0]  SND_LAST  = SND_W'(SND_DIV - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_sync1;
  logic                r_lock_s;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [HOLD_W-1:0]   w_hold_cnt_nxt;
  logic [7:0]          r_lock_drops;
  logic [7:0]          w_lock_drops_nxt;
  logic                r_rst_sys;
  logic                w_rst_sys_nxt;

  logic [CPU_W-1:0]    r_cpu_cnt;
  logic [SND_W-1:0]    r_snd_cnt;
  logic [PIX_W-1:0]    r_pix_cnt;
  logic [ACC_W-1:0]    r_fm_acc;
  logic [ACC_W:0]      w_fm_sum;
  logic                w_fm_wrap;
  logic                r_cen_cpu;
  logic                r_cen_cpu_n;
  logic                r_cen_snd;
  logic                r_cen_pix;
  logic                r_cen_fm;

  // Two-flop synchronizer bringing the PLL lock flag into the clk domain
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= i_pll_locked;
      r_lock_s <= r_sync1;
    end
  end

  // Reset sequencer state register and its registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_WAIT_LOCK;
      r_hold_cnt   <= '0;
      r_lock_drops <= '0;
      r_rst_sys    <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_lock_drops <= w_lock_drops_nxt;
      r_rst_sys    <= w_rst_sys_nxt;
    end
  end

  // Reset sequencer next-state: lock loss always wins over the hold terminal count
  always_comb begin
    w_state_nxt      = r_state;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_lock_drops_nxt = r_lock_drops;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_hold_cnt_nxt = '0;
          w_state_nxt    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          if (r_lock_drops != 8'hFF) begin
            w_lock_drops_nxt = r_lock_drops + 8'd1;
          end
        end
      end
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
    w_rst_sys_nxt = (w_state_nxt != ST_RUN);
  end

  // 17-bit compare so the accumulator sum cannot overflow before the wrap test
  always_comb begin
    w_fm_sum  = {1'b0, r_fm_acc} + (ACC_W + 1)'(FM_NUM);
    w_fm_wrap = (w_fm_sum >= (ACC_W + 1)'(FM_DEN));
  end

  // Pixel divider: free-running, never paused so video keeps going
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pix_cnt <= '0;
      r_cen_pix <= 1'b0;
    end else begin
      r_pix_cnt <= (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + PIX_W'(1);
      r_cen_pix <= (r_pix_cnt == PIX_LAST);
    end
  end

  // CPU, sound and FM enables: phase frozen while paused, enables forced low
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cpu_cnt   <= '0;
      r_snd_cnt   <= '0;
      r_fm_acc    <= '0;
      r_cen_cpu   <= 1'b0;
      r_cen_cpu_n <= 1'b0;
      r_cen_snd   <= 1'b0;
      r_cen_fm    <= 1'b0;
    end else if (i_pause) begin
      r_cen_cpu   <= 1'b0;
      r_cen_cpu_n <= 1'b0;
      r_cen_snd   <= 1'b0;
      r_cen_fm    <= 1'b0;
    end else begin
      r_cpu_cnt   <= (r_cpu_cnt == CPU_LAST) ? '0 : r_cpu_cnt + CPU_W'(1);
      r_snd_cnt   <= (r_snd_cnt == SND_LAST) ? '0 : r_snd_cnt + SND_W'(1);
      r_cen_cpu   <= (r_cpu_cnt == CPU_LAST);
      r_cen_cpu_n <= (r_cpu_cnt == CPU_HALF);
      r_cen_snd   <= (r_snd_cnt == SND_LAST);
      r_cen_fm    <= w_fm_wrap;
      r_fm_acc    <= w_fm_wrap ? ACC_W'(w_fm_sum - (ACC_W + 1)'(FM_DEN)) : w_fm_sum[ACC_W-1:0];
    end
  end

  assign o_rst_sys    = r_rst_sys;
  assign o_cen_cpu    = r_cen_cpu;
  assign o_cen_cpu_n  = r_cen_cpu_n;
  assign o_cen_snd    = r_cen_snd;
  assign o_cen_pix    = r_cen_pix;
  assign o_cen_fm     = r_cen_fm;
  assign o_lock_drops = r_lock_drops;

endmodule

// File: tb/tb_toaplan_clk_rst_gen.sv
// Self-checking bench for toaplan_clk_rst_gen: directed scenarios plus random
// rst/lock/pause traffic, compared every cycle against an arithmetic reference model.
module tb_toaplan_clk_rst_gen;

  localparam int unsigned H      = 16;
  localparam int unsigned CPU_D  = 7;
  localparam int unsigned SND_D  = 20;
  localparam int unsigned PIX_D  = 10;
  localparam longint      FM_N   = 63;
  localparam longint      FM_D   = 1232;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll;
  logic       pause;
  logic       rst_sys, cen_cpu, cen_cpu_n, cen_snd, cen_pix, cen_fm;
  logic [7:0] lock_drops;

  always #5 clk = ~clk;

  toaplan_clk_rst_gen #(
    .CPU_DIV (CPU_D),
    .SND_DIV (SND_D),
    .PIX_DIV (PIX_D),
    .FM_NUM  (63),
    .FM_DEN  (1232),
    .RST_HOLD(H)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pll_locked(pll),
    .i_pause     (pause),
    .o_rst_sys   (rst_sys),
    .o_cen_cpu   (cen_cpu),
    .o_cen_cpu_n (cen_cpu_n),
    .o_cen_snd   (cen_snd),
    .o_cen_pix   (cen_pix),
    .o_cen_fm    (cen_fm),
    .o_lock_drops(lock_drops)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: lock history, lock streak, active/total cycle counts
  bit     m_p1, m_p2;
  int     m_streak, m_drops;
  longint m_act, m_tot;
  bit     e_rst_sys, e_cpu, e_cpun, e_snd, e_pix, e_fm;

  // Pulse statistics for the directed windows
  int c_cpu, c_cpun, c_snd, c_pix, c_fm, c_adj;
  int p_cpu, p_cpun, p_snd, p_fm;
  bit prev_cpu, prev_cpun, prev_snd, prev_pix, prev_fm;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  task automatic clr_counts();
    c_cpu = 0; c_cpun = 0; c_snd = 0; c_pix = 0; c_fm = 0; c_adj = 0;
    p_cpu = 0; p_cpun = 0; p_snd = 0; p_fm = 0;
  endtask

  // One clock edge: advance the model with the inputs the DUT saw, then compare
  task automatic tick();
    bit l;
    bit was_run;
    @(posedge clk);
    if (rst) begin
      m_p1 = 0; m_p2 = 0; m_streak = 0; m_drops = 0; m_act = 0; m_tot = 0;
      e_rst_sys = 1; e_cpu = 0; e_cpun = 0; e_snd = 0; e_pix = 0; e_fm = 0;
    end else begin
      l = m_p2;
      m_p2 = m_p1;
      m_p1 = pll;
      was_run = (m_streak >= int'(H) + 1);
      if (l) begin
        if (m_streak < 1000000) m_streak++;
      end else begin
        if (was_run && m_drops < 255) m_drops++;
        m_streak = 0;
      end
      e_rst_sys = !(m_streak >= int'(H) + 1);
      m_tot++;
      e_pix = (m_tot % PIX_D) == 0;
      if (pause) begin
        e_cpu = 0; e_cpun = 0; e_snd = 0; e_fm = 0;
      end else begin
        m_act++;
        e_cpu  = (m_act % CPU_D) == 0;
        e_cpun = (m_act % CPU_D) == (CPU_D / 2);
        e_snd  = (m_act % SND_D) == 0;
        e_fm   = ((m_act * FM_N) / FM_D) != (((m_act - 1) * FM_N) / FM_D);
      end
    end
    #1;
    check_val("rst_sys",    rst_sys,    e_rst_sys);
    check_val("cen_cpu",    cen_cpu,    e_cpu);
    check_val("cen_cpu_n",  cen_cpu_n,  e_cpun);
    check_val("cen_snd",    cen_snd,    e_snd);
    check_val("cen_pix",    cen_pix,    e_pix);
    check_val("cen_fm",     cen_fm,     e_fm);
    check_val("lock_drops", int'(lock_drops), m_drops);
    if (cen_cpu   && prev_cpu)  c_adj++;
    if (cen_cpu_n && prev_cpun) c_adj++;
    if (cen_snd   && prev_snd)  c_adj++;
    if (cen_pix   && prev_pix)  c_adj++;
    if (cen_fm    && prev_fm)   c_adj++;
    if (cen_cpu)   c_cpu++;
    if (cen_cpu_n) c_cpun++;
    if (cen_snd)   c_snd++;
    if (cen_pix)   c_pix++;
    if (cen_fm)    c_fm++;
    if (pause && cen_cpu)   p_cpu++;
    if (pause && cen_cpu_n) p_cpun++;
    if (pause && cen_snd)   p_snd++;
    if (pause && cen_fm)    p_fm++;
    prev_cpu = cen_cpu; prev_cpun = cen_cpun_bit(); prev_snd = cen_snd;
    prev_pix = cen_pix; prev_fm = cen_fm;
  endtask

  function automatic bit cen_cpun_bit();
    return cen_cpu_n;
  endfunction

  // Release reset with lock high and confirm the rst_sys fall edge
  task automatic startup(input string tag);
    rst = 0;
    pll = 1;
    for (int e = 1; e <= int'(H) + 4; e++) begin
      tick();
      if (e == int'(H) + 2) check_val({tag, "_rst_hold"}, rst_sys, 1);
      if (e == int'(H) + 3) check_val({tag, "_rst_fall"}, rst_sys, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rst_sys"}, rst_sys, 1);
    check_val({tag, "_cens"}, int'({cen_cpu, cen_cpu_n, cen_snd, cen_pix, cen_fm}), 0);
    check_val({tag, "_drops"}, int'(lock_drops), 0);
  endtask

  initial begin
    rst = 1; pll = 0; pause = 0;
    clr_counts();
    prev_cpu = 0; prev_cpun = 0; prev_snd = 0; prev_pix = 0; prev_fm = 0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // Scenario 1-3: startup then long free run
    rst = 0; pll = 1;
    clr_counts();
    for (int e = 1; e <= 12320; e++) begin
      tick();
      if (e == int'(H) + 2) check_val("s1_rst_hold", rst_sys, 1);
      if (e == int'(H) + 3) check_val("s1_rst_fall", rst_sys, 0);
      if (e == 700) begin
        check_val("s2_cpu_700",  c_cpu,  100);
        check_val("s2_cpun_700", c_cpun, 100);
        check_val("s2_snd_700",  c_snd,  35);
        check_val("s2_pix_700",  c_pix,  70);
        check_val("s2_drops",    int'(lock_drops), 0);
      end
    end
    check_val("s3_fm_12320",  c_fm,  630);
    check_val("s3_cpu_12320", c_cpu, 1760);
    check_val("s3_pix_12320", c_pix, 1232);
    check_val("s3_adjacent",  c_adj, 0);

    // Scenario 4: 50-cycle pause mid-stream
    clr_counts();
    repeat (33) tick();
    pause = 1;
    repeat (50) tick();
    pause = 0;
    check_val("s4_pause_cpu",  p_cpu,  0);
    check_val("s4_pause_cpun", p_cpun, 0);
    check_val("s4_pause_snd",  p_snd,  0);
    check_val("s4_pause_fm",   p_fm,   0);
    repeat (67) tick();
    check_val("s4_cpu_total", c_cpu, 14);
    check_val("s4_pix_total", c_pix, 15);

    // Scenario 5: single-cycle lock drop in RUN, then saturation
    pll = 0;
    tick();
    pll = 1;
    for (int e = 1; e <= int'(H) + 4; e++) begin
      tick();
      if (e == 1) check_val("s5_still_run", rst_sys, 0);
      if (e == 2) begin
        check_val("s5_rst_reassert", rst_sys, 1);
        check_val("s5_drops_one", int'(lock_drops), 1);
      end
      if (e == int'(H) + 2) check_val("s5_rehold", rst_sys, 1);
      if (e == int'(H) + 3) check_val("s5_refall", rst_sys, 0);
    end
    for (int d = 0; d < 299; d++) begin
      pll = 0;
      pause = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 3)) tick();
      pll = 1;
      for (int e = 0; e < int'(H) + 4; e++) begin
        pause = ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    pause = 0;
    tick();
    check_val("s5_drops_sat", int'(lock_drops), 255);
    check_val("s5_run_after", rst_sys, 0);

    // Scenario 6: rst during HOLD, then rst during pause
    pll = 0;
    repeat (4) tick();
    pll = 1;
    repeat (10) tick();
    rst = 1;
    tick();
    check_reset_outputs("s6_hold_rst");
    startup("s6a");
    pause = 1;
    repeat (5) tick();
    rst = 1;
    tick();
    check_reset_outputs("s6_pause_rst");
    pause = 0;
    startup("s6b");

    // Random traffic on rst, lock and pause
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) pll = ~pll;
      else if (!pll && $urandom_range(0, 3) == 0) pll = 1;
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      tick();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
